fifo_rd_stream: RTL and testbench
=================================

// Module: fifo_rd_stream
// PURPOSE
// - Read-side drain stage directly downstream of the async FIFO, in the rd_clk domain.
// - Pulls words from the FIFO read port (registered data, 1-cycle read latency).
// - Re-presents the words as a valid/ready stream with a 2-entry skid buffer: 1 word/cycle, no bubbles.
// - Frames the stream into packets of PKT_LEN words (m_last) and counts completed packets.
// PARAMETERS
// - DWIDTH   32  data width; must equal FIFO DWIDTH.
// - PKT_LEN  8   words per packet; legal range 2..256.
// - CNT_W    16  width of the completed-packet counter.
// PORTS
// - rd_clk     in   1       single clock; all logic on posedge.
// - rstrn      in   1       synchronous, active-low reset.
// - flush      in   1       synchronous drop of buffered/in-flight words and packet framing.
// - fifo_empty in   1       FIFO empty flag.
// - fifo_dout  in   DWIDTH  FIFO read data; valid the cycle after an accepted read.
// - fifo_rd_en out  1       FIFO read enable (combinational).
// - m_valid    out  1       output word valid.
// - m_ready    in   1       downstream accepts the word.
// - m_data     out  DWIDTH  output word.
// - m_last     out  1       final word of a packet.
// - pkt_cnt    out  CNT_W   completed packets.
// BEHAVIOUR
// - Reset: rstrn=0 sampled at posedge rd_clk.
//   - m_valid=0, m_data=0, m_last=0, pkt_cnt=0.
//   - Buffer occupancy occ=0, inflight=0, word_cnt=0.
//   - fifo_rd_en=0 whenever rstrn=0. Reset mid-packet discards everything.
// - Definitions:
//   - pop = m_valid & m_ready.
//   - fifo_rd_en = rstrn & !flush & !fifo_empty & (occ + inflight - pop < 2).
//   - A read is accepted when fifo_rd_en=1 at a posedge.
// - inflight: register set to fifo_rd_en each cycle.
// - Capture: when inflight=1, fifo_dout is written into the buffer tail at the next posedge.
//   - Each captured word carries last = (word_cnt == PKT_LEN-1).
//   - word_cnt then increments, wrapping PKT_LEN-1 -> 0.
// - Latency: read accepted at edge E0 -> captured at E1 -> m_valid=1 after E1 (empty buffer case).
// - Throughput: with m_ready held high, a read is issued every cycle; sustained 1 word/cycle.
// - Buffer: 2-entry FIFO; m_data/m_last always show the head entry; m_valid = (occ != 0).
//   - Pop and capture in the same cycle are both honoured; occ is unchanged.
//   - occ never exceeds 2; no word is ever dropped or duplicated.
// - Stream rule: while m_valid=1 and m_ready=0, m_data and m_last hold stable.
//   - m_valid never deasserts without a pop.
// - pkt_cnt increments on a pop with m_last=1; wraps modulo 2^CNT_W.
// - flush=1 at a posedge: occ=0, inflight=0, word_cnt=0, m_valid=0.
//   - The in-flight FIFO word is discarded: capture is suppressed that edge.
//   - pkt_cnt is preserved. Priority: reset > flush > capture/pop.
// - FIFO empty: fifo_rd_en stays 0; m_valid drops after the buffer drains.
// TESTING
// - Reset with fifo_empty=0: fifo_rd_en=0, m_valid=0, pkt_cnt=0; first read 1 cycle after rstrn=1.
// - Write 8 words 0x1..0x8 upstream, m_ready=1: 8 beats on consecutive cycles; m_last only on 0x8; pkt_cnt=1.
// - m_ready=0 with words available: fifo_rd_en stops after 2 reads; m_data holds 0x1.
//   - m_ready=1 afterwards: 0x1, 0x2, 0x3 in order, no gaps.
// - Toggle m_ready every cycle over 16 words: order intact; m_last on words 8 and 16; pkt_cnt=2.
// - flush at word 5 with a read in flight: m_valid=0 next cycle; the in-flight word is never output.
//   - The next word output has word_cnt=0; m_last on the 8th word after the flush.
// - FIFO empties mid-packet (3 words): 3 beats, m_valid=0 afterwards.
//   - Refill with 5 words: m_last on the 5th; pkt_cnt increments by 1.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage behind the async FIFO (rd_clk domain).
// Issues FIFO reads with 1-cycle data latency and re-presents the words
// as a valid/ready stream through a 2-entry skid buffer. The stream is
// framed into PKT_LEN-word packets, and the stage counts completed packets.
module fifo_rd_stream #(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned PKT_LEN = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              rd_clk,
  input  logic              rstrn,
  input  logic              flush,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last,
  output logic [CNT_W-1:0]  pkt_cnt
);

  localparam int unsigned WC_W = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(PKT_LEN - 1);

  logic [1:0]        occ_q, occ_n;
  logic              inflight_q, inflight_n;
  logic [WC_W-1:0]   wc_q, wc_n;
  logic [DWIDTH-1:0] head_d_q, head_d_n, tail_d_q, tail_d_n;
  logic              head_l_q, head_l_n, tail_l_q, tail_l_n;
  logic              valid_q, valid_n;
  logic [CNT_W-1:0]  pkt_q, pkt_n;

  logic              pop;
  logic              cap;
  logic              cap_last;
  logic [2:0]        fill;

  // Read issue: keep buffered plus in-flight words within the 2 free slots
  always_comb begin
    pop        = valid_q & m_ready;
    cap        = inflight_q & ~flush;
    cap_last   = (wc_q == WC_MAX);
    fill       = 3'({1'b0, occ_q}) + 3'(inflight_q) - 3'(pop);
    fifo_rd_en = rstrn & ~flush & ~fifo_empty & (fill < 3'd2);
  end

  // Next-state: skid buffer, packet framing and counter
  always_comb begin
    occ_n      = occ_q;
    inflight_n = fifo_rd_en;
    wc_n       = wc_q;
    head_d_n   = head_d_q;
    head_l_n   = head_l_q;
    tail_d_n   = tail_d_q;
    tail_l_n   = tail_l_q;
    pkt_n      = pkt_q;

    if (flush) begin
      occ_n      = 2'd0;
      inflight_n = 1'b0;
      wc_n       = '0;
    end else begin
      if (pop && head_l_q) begin
        pkt_n = pkt_q + CNT_W'(1);
      end
      if (cap) begin
        wc_n = cap_last ? '0 : wc_q + WC_W'(1);
      end
      case (occ_q)
        2'd0: begin
          if (cap) begin
            head_d_n = fifo_dout;
            head_l_n = cap_last;
            occ_n    = 2'd1;
          end
        end
        2'd1: begin
          if (pop && cap) begin
            head_d_n = fifo_dout;
            head_l_n = cap_last;
          end else if (pop) begin
            occ_n = 2'd0;
          end else if (cap) begin
            tail_d_n = fifo_dout;
            tail_l_n = cap_last;
            occ_n    = 2'd2;
          end
        end
        default: begin
          if (pop) begin
            head_d_n = tail_d_q;
            head_l_n = tail_l_q;
            if (cap) begin
              tail_d_n = fifo_dout;
              tail_l_n = cap_last;
            end else begin
              occ_n = 2'd1;
            end
          end
        end
      endcase
    end
    valid_n = (occ_n != 2'd0);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge rd_clk) begin
    if (!rstrn) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      wc_q       <= '0;
      head_d_q   <= '0;
      head_l_q   <= 1'b0;
      tail_d_q   <= '0;
      tail_l_q   <= 1'b0;
      valid_q    <= 1'b0;
      pkt_q      <= '0;
    end else begin
      occ_q      <= occ_n;
      inflight_q <= inflight_n;
      wc_q       <= wc_n;
      head_d_q   <= head_d_n;
      head_l_q   <= head_l_n;
      tail_d_q   <= tail_d_n;
      tail_l_q   <= tail_l_n;
      valid_q    <= valid_n;
      pkt_q      <= pkt_n;
    end
  end

  // Stream outputs always reflect the buffer head
  always_comb begin
    m_valid = valid_q;
    m_data  = head_d_q;
    m_last  = head_l_q;
    pkt_cnt = pkt_q;
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: upstream FIFO model, scoreboard queue and
// an independent output monitor.
module tb_fifo_rd_stream;

  logic        rd_clk = 1'b0;
  logic        rstrn;
  logic        flush;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_dout = '0;
  logic        fifo_rd_en;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic [15:0] pkt_cnt;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  logic [31:0] up_q[$];
  exp_t        exp_q[$];
  int          beat_cyc[$];
  int          exp_wc = 0;
  int          checks = 0;
  int          failures = 0;
  int          beat_cnt = 0;
  int          cyc = 0;
  logic        prev_stall = 1'b0;
  logic        prev_flush = 1'b0;
  logic [32:0] prev_word = '0;

  fifo_rd_stream #(.DWIDTH(32), .PKT_LEN(8), .CNT_W(16)) dut (
    .rd_clk    (rd_clk),
    .rstrn     (rstrn),
    .flush     (flush),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .pkt_cnt   (pkt_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  // Upstream FIFO model: registered read data, one cycle after rd_en
  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      if (up_q.size() != 0) fifo_dout <= up_q.pop_front();
      fifo_empty <= (up_q.size() == 0);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on each handshake, checks hold rule
  always @(negedge rd_clk) begin
    exp_t e;
    cyc++;
    if (rstrn) begin
      if (prev_stall && !prev_flush) begin
        chk("hold_valid", 64'(m_valid), 64'd1);
        chk("hold_word", 64'({m_last, m_data}), 64'(prev_word));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=0x%0h expected=none", m_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 64'(m_data), 64'(e.d));
          chk("beat_last", 64'(m_last), 64'(e.l));
        end
        beat_cnt++;
        beat_cyc.push_back(cyc);
      end
    end
    prev_stall = rstrn && m_valid && !m_ready;
    prev_flush = flush;
    prev_word  = {m_last, m_data};
  end

  task automatic push_exp(input logic [31:0] d);
    exp_t e;
    e.d = d;
    e.l = (exp_wc == 7);
    exp_q.push_back(e);
    exp_wc = (exp_wc == 7) ? 0 : exp_wc + 1;
  endtask

  task automatic push_words(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      up_q.push_back(first + 32'(i));
      push_exp(first + 32'(i));
    end
    if (n > 0) fifo_empty <= 1'b0;
  endtask

  task automatic wait_beats(input int target, input string name);
    int k;
    k = 0;
    while (beat_cnt < target && k < 200) begin
      @(negedge rd_clk);
      #1;
      k++;
    end
    if (beat_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d expected=%0d", name, beat_cnt, target);
    end
  endtask

  task automatic chk_consec(input int n, input string name);
    if (beat_cyc.size() >= n) chk(name, 64'(beat_cyc[n-1] - beat_cyc[0]), 64'(n - 1));
    else chk(name, 64'(beat_cyc.size()), 64'(n));
  endtask

  initial begin
    int base;
    int rd_count;
    int r;
    rstrn   = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge rd_clk);
    #1;

    // Reset with data waiting upstream, then 8-word packet at full rate
    push_words(32'h1, 8);
    m_ready = 1'b1;
    @(negedge rd_clk);
    chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_data", 64'(m_data), 64'd0);
    chk("rst_last", 64'(m_last), 64'd0);
    chk("rst_pkt", 64'(pkt_cnt), 64'd0);
    @(posedge rd_clk);
    #1 rstrn = 1'b1;
    beat_cyc.delete();
    @(negedge rd_clk);
    chk("first_rd_en", 64'(fifo_rd_en), 64'd1);
    @(negedge rd_clk);
    chk("lat_valid_e0", 64'(m_valid), 64'd0);
    @(negedge rd_clk);
    chk("lat_valid_e1", 64'(m_valid), 64'd1);
    chk("lat_data_e1", 64'(m_data), 64'h1);
    wait_beats(8, "pkt1");
    chk_consec(8, "pkt1_consec");
    @(posedge rd_clk);
    #1 chk("pkt1_cnt", 64'(pkt_cnt), 64'd1);

    // Backpressure: only two reads issued, head holds
    m_ready = 1'b0;
    push_words(32'h11, 8);
    rd_count = 0;
    repeat (8) begin
      @(negedge rd_clk);
      if (fifo_rd_en) rd_count++;
    end
    chk("bp_reads", 64'(rd_count), 64'd2);
    chk("bp_valid", 64'(m_valid), 64'd1);
    chk("bp_head", 64'(m_data), 64'h11);
    @(posedge rd_clk);
    #1;
    base = beat_cnt;
    beat_cyc.delete();
    m_ready = 1'b1;
    wait_beats(base + 8, "bp");
    chk_consec(8, "bp_consec");
    @(posedge rd_clk);
    #1 chk("bp_pkt", 64'(pkt_cnt), 64'd2);

    // Toggling ready over 16 words
    base = beat_cnt;
    push_words(32'h21, 16);
    for (int k = 0; k < 200 && beat_cnt < base + 16; k++) begin
      @(posedge rd_clk);
      #1 m_ready = ~m_ready;
    end
    chk("tog_beats", 64'(beat_cnt - base), 64'd16);
    m_ready = 1'b1;
    @(posedge rd_clk);
    #1 chk("tog_pkt", 64'(pkt_cnt), 64'd4);

    // Flush mid-stream with a read in flight
    base = beat_cnt;
    push_words(32'h41, 12);
    wait_beats(base + 4, "pre_flush");
    @(posedge rd_clk);
    #1;
    m_ready = 1'b0;
    flush   = 1'b1;
    @(posedge rd_clk);
    #1;
    flush = 1'b0;
    chk("flush_valid", 64'(m_valid), 64'd0);
    chk("flush_pkt", 64'(pkt_cnt), 64'd4);
    exp_q.delete();
    exp_wc = 0;
    r = up_q.size();
    for (int i = 0; i < r; i++) push_exp(up_q[i]);
    if (r < 8) push_words(32'h51, 8 - r);
    base = beat_cnt;
    m_ready = 1'b1;
    wait_beats(base + ((r < 8) ? 8 : r), "post_flush");
    @(posedge rd_clk);
    #1 chk("post_flush_pkt", 64'(pkt_cnt), 64'd5);

    // FIFO runs dry mid-packet, then refill completes it
    base = beat_cnt;
    push_words(32'h61, 3);
    wait_beats(base + 3, "dry");
    repeat (3) @(negedge rd_clk);
    chk("dry_valid", 64'(m_valid), 64'd0);
    chk("dry_rd_en", 64'(fifo_rd_en), 64'd0);
    #1 push_words(32'h64, 5);
    wait_beats(base + 8, "refill");
    @(posedge rd_clk);
    #1 chk("refill_pkt", 64'(pkt_cnt), 64'd6);

    repeat (4) @(posedge rd_clk);
    #1;
    chk("exp_drained", 64'(exp_q.size()), 64'd0);
    chk("up_drained", 64'(up_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
